// File: rtl/frame_segmenter.sv
// Overlapping frame segmenter: buffers a sample stream in a 2*FRAME_LEN circular
// buffer and replays FRAME_LEN-sample frames whose starts are HOP samples apart.
module frame_segmenter #(
  parameter int unsigned DATA_W    = 20,
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned HOP       = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         flush,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_valid,
  output logic [$clog2(FRAME_LEN)-1:0] out_num,
  output logic                         out_last,
  output logic [15:0]                  frame_cnt
);

  localparam int unsigned DEPTH = 2 * FRAME_LEN;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned NW    = $clog2(FRAME_LEN);

  localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
  localparam logic [CW-1:0] FRAME_C  = CW'(FRAME_LEN);
  localparam logic [CW-1:0] HOP_C    = CW'(HOP);
  localparam logic [AW-1:0] HOP_A    = AW'(HOP);
  localparam logic [NW-1:0] LAST_IDX = NW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    EMIT    = 2'd1,
    ADVANCE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     base;
  logic [CW-1:0]     count;
  logic [NW-1:0]     rd_idx;
  logic [AW-1:0]     rd_addr;
  logic              accept;
  logic              rd_en_c;
  logic              adv_c;
  logic [DATA_W-1:0] mem [DEPTH];

  assign in_ready = (count < FULL_C) & ~flush;
  assign accept   = in_valid & in_ready;
  assign rd_addr  = base + AW'(rd_idx);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; flush always returns to FILL
  always_comb begin
    state_nx = state;
    case (state)
      FILL:    if (count >= FRAME_C) state_nx = EMIT;
      EMIT:    if (rd_idx == LAST_IDX) state_nx = ADVANCE;
      ADVANCE: state_nx = FILL;
      default: state_nx = FILL;
    endcase
    if (flush) state_nx = FILL;
  end

  // FSM control outputs
  always_comb begin
    rd_en_c = 1'b0;
    adv_c   = 1'b0;
    case (state)
      EMIT:    rd_en_c = 1'b1;
      ADVANCE: adv_c   = 1'b1;
      default: ;
    endcase
  end

  // Sample storage; no reset so it maps onto a RAM
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= in_data;
  end

  // Pointers, occupancy and registered frame output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      base      <= '0;
      count     <= '0;
      rd_idx    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_num   <= '0;
      out_last  <= 1'b0;
      frame_cnt <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      base      <= '0;
      count     <= '0;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      out_num   <= '0;
      out_last  <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      // write and hop release may coincide; both apply
      count <= count + CW'(accept) - (adv_c ? HOP_C : '0);
      if (adv_c) begin
        base      <= base + HOP_A;
        frame_cnt <= frame_cnt + 16'd1;
      end
      rd_idx    <= rd_en_c ? rd_idx + NW'(1) : '0;
      out_valid <= rd_en_c;
      out_num   <= rd_en_c ? rd_idx : '0;
      out_last  <= rd_en_c && (rd_idx == LAST_IDX);
      if (rd_en_c) out_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_frame_segmenter.sv
// Scoreboard bench for frame_segmenter: a sample-history model predicts every
// frame from the accepted stream; a negedge monitor pops and compares outputs.
module tb_frame_segmenter;

  localparam int unsigned DW  = 20;
  localparam int unsigned FL  = 1024;
  localparam int unsigned HP  = 256;
  localparam int unsigned NW  = 10;
  localparam int unsigned N_B = 3100;

  typedef struct {
    logic [DW-1:0] d;
    int            num;
    bit            last;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [NW-1:0] out_num;
  logic          out_last;
  logic [15:0]   frame_cnt;

  frame_segmenter #(.DATA_W(DW), .FRAME_LEN(FL), .HOP(HP)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_data(out_data),
    .out_valid(out_valid), .out_num(out_num), .out_last(out_last),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_pass = 0;
  int            n_total = 0;
  logic [DW-1:0] hist[$];
  exp_t          exp_q[$];
  int            nxt_frame = 0;
  int            frames_seen = 0;
  bit            mid = 0;
  bit            prev_v = 0;
  bit            abort = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  // Frame k is samples k*HP .. k*HP+FL-1 of the accepted stream
  task automatic model_push(input logic [DW-1:0] d);
    exp_t e;
    hist.push_back(d);
    while (hist.size() >= nxt_frame * HP + FL) begin
      for (int i = 0; i < FL; i++) begin
        e.d    = hist[nxt_frame * HP + i];
        e.num  = i;
        e.last = (i == FL - 1);
        exp_q.push_back(e);
      end
      nxt_frame++;
    end
  endtask

  task automatic model_clear();
    hist.delete();
    exp_q.delete();
    nxt_frame = 0;
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit f, output bit acc);
    @(negedge clk);
    #2;
    in_valid = v;
    in_data  = d;
    flush    = f;
    #1;
    acc = v && in_ready && rst_n && !f;
    if (acc) model_push(d);
  endtask

  // Monitor: compare every presented output against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      mid = 0;
      prev_v = 0;
      frames_seen = 0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk(0, "spurious_out_valid", out_num, -1);
        end else begin
          e = exp_q.pop_front();
          chk(out_data == e.d, "out_data", out_data, e.d);
          chk(out_num == NW'(e.num), "out_num", out_num, e.num);
          chk(out_last == e.last, "out_last", out_last, e.last);
          if (e.num == 0) begin
            chk(!prev_v, "gap_between_frames", prev_v, 0);
            chk(frame_cnt == 16'(frames_seen), "frame_cnt_at_start", frame_cnt, frames_seen);
          end
          if (e.last) begin
            frames_seen++;
            mid = 0;
          end else begin
            mid = 1;
          end
        end
      end else if (mid) begin
        if (abort) mid = 0;
        else begin
          chk(0, "mid_frame_drop", 0, 1);
          mid = 0;
        end
      end
      prev_v = out_valid;
    end
  end

  task automatic drain(input string name);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk(exp_q.size() == 0, name, exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  // Ramp 0..FL-1 continuously and measure edges from last accept to out_valid
  task automatic ramp_first_frame(output int lat);
    bit acc;
    lat = 0;
    for (int n = 0; n < FL; n++) begin
      drive(1'b1, DW'(n), 1'b0, acc);
      chk(acc, "ramp_accept", acc, 1);
    end
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk(out_valid == 1'b0, {tag, "_out_valid"}, out_valid, 0);
    chk(out_data == '0, {tag, "_out_data"}, out_data, 0);
    chk(out_num == '0, {tag, "_out_num"}, out_num, 0);
    chk(out_last == 1'b0, {tag, "_out_last"}, out_last, 0);
    chk(frame_cnt == 16'd0, {tag, "_frame_cnt"}, frame_cnt, 0);
    chk(in_ready == 1'b1, {tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    bit acc;
    bit saw_full;
    int lat;
    int accepted;
    int cyc;
    logic [15:0] fc_before;
    logic [DW-1:0] d;

    in_valid = 1'b0;
    in_data  = '0;
    flush    = 1'b0;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_zero("reset");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // First frame latency, then continuous ramp into backpressure
    ramp_first_frame(lat);
    chk(lat == 3, "first_frame_latency", lat, 3);
    accepted = FL;
    saw_full = 0;
    cyc = 0;
    while (accepted < N_B && cyc < 10000) begin
      drive(1'b1, DW'(accepted), 1'b0, acc);
      if (acc) accepted++;
      else saw_full = 1;
      cyc++;
    end
    drive(1'b0, '0, 1'b0, acc);
    chk(accepted == N_B, "ramp_total", accepted, N_B);
    chk(saw_full, "in_ready_low_when_full", saw_full, 1);
    drain("ramp_drain");
    chk(frame_cnt == 16'((N_B - FL) / HP + 1), "ramp_frame_cnt", frame_cnt, (N_B - FL) / HP + 1);

    // Idle flush keeps frame_cnt, then random data with ~50% valid
    fc_before = frame_cnt;
    drive(1'b1, DW'(77), 1'b1, acc);
    chk(in_ready == 1'b0, "in_ready_during_flush", in_ready, 0);
    model_clear();
    drive(1'b0, '0, 1'b0, acc);
    chk(frame_cnt == fc_before, "idle_flush_frame_cnt", frame_cnt, fc_before);
    for (int i = 0; i < 5000; i++) begin
      d = DW'($urandom);
      drive($urandom_range(0, 1) == 1, d, 1'b0, acc);
    end
    drive(1'b0, '0, 1'b0, acc);
    drain("random_drain");

    // Flush at out_num == 500 aborts the frame
    cyc = 0;
    while (!(out_valid && out_num == NW'(500)) && cyc < 6000) begin
      drive(1'b1, DW'($urandom), 1'b0, acc);
      cyc++;
    end
    chk(out_valid && out_num == NW'(500), "reach_num_500", out_num, 500);
    fc_before = frame_cnt;
    abort = 1;
    drive(1'b1, DW'($urandom), 1'b1, acc);
    model_clear();
    @(posedge clk);
    #1;
    chk(out_valid == 1'b0, "flush_out_valid", out_valid, 0);
    chk(out_last == 1'b0, "flush_out_last", out_last, 0);
    chk(frame_cnt == fc_before, "flush_frame_cnt", frame_cnt, fc_before);
    drive(1'b0, '0, 1'b0, acc);
    abort = 0;
    for (int i = 0; i < 1100; i++) begin
      drive(1'b1, DW'($urandom), 1'b0, acc);
    end
    drive(1'b0, '0, 1'b0, acc);
    drain("post_flush_drain");

    // Asynchronous reset mid-frame, then the first-frame behaviour again
    cyc = 0;
    while (!(out_valid && out_num == NW'(300)) && cyc < 6000) begin
      drive(1'b1, DW'($urandom), 1'b0, acc);
      cyc++;
    end
    chk(out_valid && out_num == NW'(300), "reach_num_300", out_num, 300);
    #1 rst_n = 1'b0;
    model_clear();
    #1;
    check_zero("async_reset");
    repeat (3) drive(1'b0, '0, 1'b0, acc);
    @(negedge clk);
    #2 rst_n = 1'b1;
    ramp_first_frame(lat);
    chk(lat == 3, "post_reset_latency", lat, 3);
    drain("post_reset_drain");
    chk(frame_cnt == 16'd1, "post_reset_frame_cnt", frame_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
